// File: rtl/ps2_kbd_mmio_if.sv
// CPU-side MMIO bus for the PS/2 keyboard port: address/data/write strobe in,
// status word and scancode interrupt out.
interface ps2_kbd_mmio_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] KBD_DATA;
  logic        KBD_INTR;

  modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, input KBD_DATA, KBD_INTR);
  modport slave  (input IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, output KBD_DATA, KBD_INTR);
endinterface

// File: rtl/ps2_kbd_mmio.sv
// PS/2 keyboard receiver: synchronise + glitch-filter the keyboard clock, frame
// 11-bit scancodes, queue good bytes in a small FIFO readable over MMIO.
module ps2_kbd_mmio #(
  parameter logic [31:0] KBD_DATA_AD = 32'h11000100,
  parameter logic [31:0] KBD_POP_AD  = 32'h11000104,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          FILTER_LEN  = 8,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           PS2_CLK,
  input  logic           PS2_DATA,
  ps2_kbd_mmio_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          flt_clk;
  logic [FW-1:0] flt_cnt;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          err, ovf, intr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
    end
  end

  // flt_cnt counts consecutive samples disagreeing with the filtered level
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flt_clk <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_sync[1] == flt_clk) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
      flt_clk <= clk_sync[1];
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  logic fall, bit_in, pop_do, clr_req, frame_good, push_do, ovf_set, err_set, tmo_hit, full;
  assign fall       = flt_clk && !clk_sync[1] && (flt_cnt == FW'(FILTER_LEN - 1));
  assign bit_in     = dat_sync[1];
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop_do     = bus.IOBUS_WR && (bus.IOBUS_ADDR == KBD_POP_AD) && bus.IOBUS_OUT[0]
                      && (count != '0);
  assign clr_req    = bus.IOBUS_WR && (bus.IOBUS_ADDR == KBD_POP_AD) && bus.IOBUS_OUT[1];
  assign frame_good = (state == S_STOP) && fall && bit_in && (^{shreg, par_bit});
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push_do    = frame_good && (!full || pop_do);
  assign ovf_set    = frame_good && full && !pop_do;
  assign tmo_hit    = (state != S_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign err_set    = ((state == S_STOP) && fall && !frame_good) || tmo_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
      intr    <= 1'b0;
    end else begin
      intr    <= push_do;
      tmo_cnt <= (state == S_IDLE || fall) ? '0 : tmo_cnt + 1'b1;
      if (tmo_hit) begin
        state <= S_IDLE;
      end else if (fall) begin
        case (state)
          S_IDLE: if (!bit_in) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
          S_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= bit_in;
            state   <= S_STOP;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push_do) mem[tail] <= shreg;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (push_do) tail <= tail + 1'b1;
      if (pop_do)  head <= head + 1'b1;
      if (push_do && !pop_do)      count <= count + 1'b1;
      else if (pop_do && !push_do) count <= count - 1'b1;
      if (err_set)      err <= 1'b1;
      else if (clr_req) err <= 1'b0;
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_req) ovf <= 1'b0;
    end
  end

  // count field is 4 bits wide; a 16-deep FIFO reports 0 when full (bit 8 still set)
  logic [4:0] cnt_ext;
  logic [7:0] head_byte;
  logic       unused_out;
  assign cnt_ext    = 5'(count);
  assign head_byte  = (count != '0) ? mem[head] : 8'h00;
  assign unused_out = ^{bus.IOBUS_OUT[31:2], cnt_ext[4]};

  assign bus.KBD_INTR = intr;
  assign bus.KBD_DATA = (bus.IOBUS_ADDR == KBD_DATA_AD)
                        ? {17'd0, ovf, err, cnt_ext[3:0], (count != '0), head_byte}
                        : 32'h0;
endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// Directed + randomized bench for ps2_kbd_mmio with a queue-based model of the
// keyboard FIFO and sticky flags.
module tb_ps2_kbd_mmio;
  localparam logic [31:0] DATA_AD = 32'h11000100;
  localparam logic [31:0] POP_AD  = 32'h11000104;
  localparam int DEPTH = 8;
  localparam int HALF  = 30;  // PS/2 half period in CLK cycles, kept short for run time

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  ps2_kbd_mmio_if bus();

  ps2_kbd_mmio #(.KBD_DATA_AD(DATA_AD), .KBD_POP_AD(POP_AD), .FIFO_DEPTH(DEPTH),
                 .FILTER_LEN(8), .TIMEOUT_CYC(50000)) dut (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, intr_cnt = 0, exp_intr = 0;
  byte unsigned q[$];
  bit m_err = 1'b0, m_ovf = 1'b0;

  always @(negedge clk) if (bus.KBD_INTR === 1'b1) intr_cnt++;

  function automatic logic [31:0] exp_word();
    logic [7:0] hd;
    hd = (q.size() != 0) ? q[0] : 8'h00;
    return {17'd0, m_ovf, m_err, 4'(q.size()), (q.size() != 0), hd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    bus.IOBUS_ADDR = DATA_AD;
    @(negedge clk);
    chk({tag, " word"}, bus.KBD_DATA, exp_word());
    chk({tag, " intr"}, 32'(intr_cnt), 32'(exp_intr));
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop, input bit popped);
    if (popped && q.size() != 0) void'(q.pop_front());
    if (stop && (^{d, par})) begin
      if (q.size() < DEPTH) begin
        q.push_back(d);
        exp_intr++;
      end else m_ovf = 1'b1;
    end else m_err = 1'b1;
  endtask

  // Drive one bit: data during high half, then falling edge; optional pop write
  // timed to land on the edge that consumes this falling edge (2 sync + 8 filter).
  task automatic ps2_bit(input logic b, input bit glitch, input bit pop_here);
    ps2_data = b;
    if (glitch) begin
      repeat (HALF/3) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (HALF - HALF/3 - 3) @(posedge clk);
    end else repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (pop_here) begin
      repeat (9) @(posedge clk);
      #1 bus.IOBUS_ADDR = POP_AD; bus.IOBUS_OUT = 32'h1; bus.IOBUS_WR = 1'b1;
      @(posedge clk);
      #1 bus.IOBUS_WR = 1'b0; bus.IOBUS_OUT = 32'h0; bus.IOBUS_ADDR = DATA_AD;
      repeat (HALF - 10) @(posedge clk);
    end else repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit glitch, input bit pop_stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i], glitch, pop_stop && (i == 10));
    model_frame(d, par, stop, pop_stop);
    repeat (5) @(posedge clk);
  endtask

  task automatic send_partial(input int nbits, input logic [7:0] d);
    logic [10:0] bits;
    bits = {2'b11, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], 1'b0, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] val);
    @(posedge clk);
    #1 bus.IOBUS_ADDR = POP_AD; bus.IOBUS_OUT = val; bus.IOBUS_WR = 1'b1;
    @(posedge clk);
    #1 bus.IOBUS_WR = 1'b0; bus.IOBUS_OUT = 32'h0; bus.IOBUS_ADDR = DATA_AD;
    if (val[0] && q.size() != 0) void'(q.pop_front());
    if (val[1]) begin m_err = 1'b0; m_ovf = 1'b0; end
  endtask

  initial begin
    logic [7:0] d;
    logic par, stop;
    bus.IOBUS_ADDR = DATA_AD; bus.IOBUS_OUT = 32'h0; bus.IOBUS_WR = 1'b0;
    repeat (3) @(posedge clk);
    chk_state("reset");
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("post-reset raw", bus.KBD_DATA, 32'h0);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_state("good 1C");
    chk("good 1C const", bus.KBD_DATA, 32'h0000031C);
    do_write(32'h1);
    chk_state("pop 1C");

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_state("bad parity");
    chk("bad parity const", bus.KBD_DATA, 32'h00002000);
    do_write(32'h2);
    chk_state("clear err");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), ~^(8'(i)), 1'b1, 1'b0, 1'b0);
    chk_state("overflow fill");
    chk("overflow const", bus.KBD_DATA, 32'h00005101);
    bus.IOBUS_ADDR = 32'h11000108;
    @(negedge clk);
    chk("addr miss", bus.KBD_DATA, 32'h0);
    for (int i = 0; i < 8; i++) begin
      do_write(32'h1);
      chk_state("drain");
    end
    do_write(32'h3);
    chk_state("empty pop+clear");

    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), ~^(8'h10 + 8'(i)), 1'b1, 1'b0, 1'b0);
    send_frame(8'h99, ~^(8'h99), 1'b1, 1'b0, 1'b1);
    chk_state("pop on stop edge");
    for (int i = 0; i < 8; i++) begin
      do_write(32'h1);
      chk_state("drain2");
    end

    send_frame(8'h3A, ~^(8'h3A), 1'b1, 1'b1, 1'b0);
    chk_state("glitched frame");

    send_partial(5, 8'h33);
    repeat (60000) @(posedge clk);
    m_err = 1'b1;
    chk_state("timeout");
    send_frame(8'h5A, ~^(8'h5A), 1'b1, 1'b0, 1'b0);
    chk_state("after timeout 5A");
    do_write(32'h3);
    chk_state("pop 5A");

    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ^d : ~^d;
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, par, stop, 1'b0, 1'b0);
      chk_state("random frame");
      if ($urandom_range(0, 1) == 1) begin
        do_write(32'($urandom_range(1, 3)));
        chk_state("random write");
      end
    end

    send_frame(8'h77, ~^(8'h77), 1'b1, 1'b0, 1'b0);
    send_partial(6, 8'hC3);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    chk_state("mid-frame reset");
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'hA5, ~^(8'hA5), 1'b1, 1'b0, 1'b0);
    chk_state("after reset A5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
